// File: rtl/memory_controller.sv
// Byte-wide RAM port owner: arbitrates ICache block refills against LSB loads/stores,
// sequences one byte per cycle and returns little-endian results with a one-cycle done pulse.
module memory_controller #(
    parameter int BLOCK_WIDTH = 2,
    parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,

    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [31:0]               mem_a,
    output logic                      mem_wr,
    input  logic                      io_buffer_full,

    input  logic                      IC_query_en,
    input  logic [31:0]               IC_query_addr,
    output logic                      IC_data_en,
    output logic [32*BLOCK_SIZE-1:0]  IC_data,

    input  logic                      LSB_query_en,
    input  logic                      LSB_query_wr,
    input  logic [1:0]                LSB_query_size,
    input  logic [31:0]               LSB_query_addr,
    input  logic [31:0]               LSB_query_data,
    output logic                      LSB_data_en,
    output logic [31:0]               LSB_data
);
    localparam int CW = BLOCK_WIDTH + 3;
    localparam int BW = 32 * BLOCK_SIZE;
    localparam int IW = $clog2(BW);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] IC_LEN = CW'(4 * BLOCK_SIZE);

    typedef enum logic [1:0] {IDLE, IC_READ, LSB_READ, LSB_WRITE} state_t;
    typedef enum logic {GRANT_IC, GRANT_LSB} grant_t;

    state_t          state;
    grant_t          last_grant;
    logic [31:0]     base;
    logic [31:0]     mem_a_q;
    logic            mem_wr_q;
    logic [7:0]      dout_q;
    logic [23:0]     wr_shift;
    logic [CW-1:0]   len;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   rd_buf;
    logic [BW-1:0]   cap_buf;
    logic [CW-1:0]   lsb_len;
    logic            io_stall;
    logic            reading;

    always_comb begin
        unique case (LSB_query_size)
            2'b00:   lsb_len = CW'(1);
            2'b01:   lsb_len = CW'(2);
            default: lsb_len = CW'(4);
        endcase
    end

    // cnt is the index of the byte whose address is on mem_a; byte cnt-1 is on mem_din.
    // While paused, re-present the pending byte's address so mem_din is still right on resume.
    always_comb begin
        logic [CW-1:0] byte_idx;
        logic [IW-1:0] bit_idx;
        byte_idx = cnt - ONE;
        bit_idx  = IW'({byte_idx, 3'b000});
        io_stall = (state == LSB_WRITE) && (base[17:16] == 2'b11) && io_buffer_full;
        reading  = (state == IC_READ) || (state == LSB_READ);
        mem_wr   = mem_wr_q && rdy_in && !io_stall;
        mem_dout = mem_wr ? dout_q : '0;
        mem_a    = mem_a_q;
        if (!rdy_in && reading && (cnt != '0))
            mem_a = base + 32'(byte_idx);
        cap_buf = rd_buf;
        if (cnt != '0)
            cap_buf[bit_idx +: 8] = mem_din;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            last_grant  <= GRANT_IC;
            base        <= '0;
            mem_a_q     <= '0;
            mem_wr_q    <= 1'b0;
            dout_q      <= '0;
            wr_shift    <= '0;
            len         <= '0;
            cnt         <= '0;
            rd_buf      <= '0;
            IC_data_en  <= 1'b0;
            IC_data     <= '0;
            LSB_data_en <= 1'b0;
            LSB_data    <= '0;
        end else if (rdy_in) begin
            IC_data_en  <= 1'b0;
            LSB_data_en <= 1'b0;
            case (state)
                IDLE: begin
                    // The cycle carrying a done pulse never accepts, so a requester that
                    // drops its enable on the pulse cannot be granted twice.
                    if (!IC_data_en && !LSB_data_en) begin
                        if (IC_query_en && (!LSB_query_en || last_grant == GRANT_LSB)) begin
                            state      <= IC_READ;
                            last_grant <= GRANT_IC;
                            base       <= IC_query_addr;
                            mem_a_q    <= IC_query_addr;
                            len        <= IC_LEN;
                            cnt        <= '0;
                            rd_buf     <= '0;
                        end else if (LSB_query_en) begin
                            last_grant <= GRANT_LSB;
                            base       <= LSB_query_addr;
                            mem_a_q    <= LSB_query_addr;
                            len        <= lsb_len;
                            cnt        <= '0;
                            rd_buf     <= '0;
                            if (LSB_query_wr) begin
                                state    <= LSB_WRITE;
                                mem_wr_q <= 1'b1;
                                dout_q   <= LSB_query_data[7:0];
                                wr_shift <= LSB_query_data[31:8];
                            end else begin
                                state <= LSB_READ;
                            end
                        end
                    end
                end
                IC_READ, LSB_READ: begin
                    rd_buf <= cap_buf;
                    if (cnt == len) begin
                        state <= IDLE;
                        if (state == IC_READ) begin
                            IC_data_en <= 1'b1;
                            IC_data    <= cap_buf;
                        end else begin
                            LSB_data_en <= 1'b1;
                            LSB_data    <= cap_buf[31:0];
                        end
                    end else begin
                        cnt <= cnt + ONE;
                        if (cnt + ONE != len)
                            mem_a_q <= mem_a_q + 32'd1;
                    end
                end
                LSB_WRITE: begin
                    if (!io_stall) begin
                        if (cnt == len - ONE) begin
                            state       <= IDLE;
                            mem_wr_q    <= 1'b0;
                            dout_q      <= '0;
                            LSB_data_en <= 1'b1;
                            LSB_data    <= '0;
                        end else begin
                            cnt      <= cnt + ONE;
                            mem_a_q  <= mem_a_q + 32'd1;
                            dout_q   <= wr_shift[7:0];
                            wr_shift <= {8'd0, wr_shift[23:8]};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: synchronous byte RAM model, request vector table, and
// hand-written sequences for IO stall, reset mid-refill and round-robin arbitration.
module tb_memory_controller;
    localparam int BW   = 2;
    localparam int BS   = 1 << BW;
    localparam int N_IC = 4 * BS;
    localparam int K_IC = 0;
    localparam int K_LD = 1;
    localparam int K_ST = 2;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              rdy_in = 1'b1;
    logic [7:0]        mem_din = '0;
    logic [7:0]        mem_dout;
    logic [31:0]       mem_a;
    logic              mem_wr;
    logic              io_buffer_full = 1'b0;
    logic              IC_query_en = 1'b0;
    logic [31:0]       IC_query_addr = '0;
    logic              IC_data_en;
    logic [32*BS-1:0]  IC_data;
    logic              LSB_query_en = 1'b0;
    logic              LSB_query_wr = 1'b0;
    logic [1:0]        LSB_query_size = '0;
    logic [31:0]       LSB_query_addr = '0;
    logic [31:0]       LSB_query_data = '0;
    logic              LSB_data_en;
    logic [31:0]       LSB_data;

    memory_controller #(.BLOCK_WIDTH(BW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .IC_query_en(IC_query_en), .IC_query_addr(IC_query_addr),
        .IC_data_en(IC_data_en), .IC_data(IC_data),
        .LSB_query_en(LSB_query_en), .LSB_query_wr(LSB_query_wr),
        .LSB_query_size(LSB_query_size), .LSB_query_addr(LSB_query_addr),
        .LSB_query_data(LSB_query_data), .LSB_data_en(LSB_data_en), .LSB_data(LSB_data)
    );

    typedef struct {
        int           kind;
        logic [1:0]   size;
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [127:0] exp;
        int           pause_at;
    } vec_t;
    typedef struct { bit is_ic; logic [127:0] data; } cmp_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;

    cmp_t exp_q[$];
    wr_t  wr_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [7:0] ram [0:65535];

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not as required", name);
    endtask

    // RAM: address sampled at the edge, data on mem_din the next cycle; 0x3xxxx is IO space.
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 16; i++) ram[16'h0100 + i] = 8'(i);
        ram[16'h0204] = 8'h11; ram[16'h0205] = 8'h22; ram[16'h0206] = 8'h33; ram[16'h0207] = 8'h44;
        ram[16'h0302] = 8'h00; ram[16'h0303] = 8'h00;
        ram[16'hFFFE] = 8'hA1; ram[16'hFFFF] = 8'hA2; ram[16'h0000] = 8'hA3; ram[16'h0001] = 8'hA4;
        forever begin
            @(posedge clk_in);
            mem_din <= ram[mem_a[15:0]];
            if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[15:0]] = mem_dout;
        end
    end

    // Scoreboard: writes and completions are checked late in each cycle, in issue order.
    initial forever begin
        @(negedge clk_in);
        #4;
        if (mem_wr) begin
            if (wr_q.size() == 0) flag("unexpected_write");
            else begin
                wr_t w;
                w = wr_q.pop_front();
                check("wr_addr", mem_a, w.addr);
                check("wr_data", mem_dout, w.data);
            end
        end
        if (IC_data_en || LSB_data_en) begin
            if (exp_q.size() == 0) flag("unexpected_pulse");
            else begin
                cmp_t e;
                e = exp_q.pop_front();
                check("pulse_is_ic", IC_data_en, e.is_ic);
                if (e.is_ic) check("ic_data", IC_data, e.data);
                else check("lsb_data", LSB_data, e.data);
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mem_a"}, mem_a, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_mem_dout"}, mem_dout, 0);
        check({tag, "_ic_en"}, IC_data_en, 0);
        check({tag, "_ic_data"}, IC_data, 0);
        check({tag, "_lsb_en"}, LSB_data_en, 0);
        check({tag, "_lsb_data"}, LSB_data, 0);
    endtask

    task automatic run_req(input vec_t v);
        int n, lat_exp, c0, addr_err;
        bit got;
        logic [31:0] d;
        cmp_t e;
        n = (v.kind == K_IC) ? N_IC : (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
        @(negedge clk_in);
        if (v.kind == K_IC) begin
            IC_query_addr = v.addr;
            IC_query_en   = 1'b1;
        end else begin
            LSB_query_wr   = (v.kind == K_ST);
            LSB_query_size = v.size;
            LSB_query_addr = v.addr;
            LSB_query_data = v.data;
            LSB_query_en   = 1'b1;
        end
        e.is_ic = (v.kind == K_IC);
        e.data  = v.exp;
        exp_q.push_back(e);
        d = v.data;
        if (v.kind == K_ST)
            for (int k = 0; k < n; k++) begin
                wr_q.push_back('{v.addr + 32'(k), d[7:0]});
                d = d >> 8;
            end
        lat_exp = ((v.kind == K_ST) ? n + 1 : n + 2) + ((v.pause_at > 0) ? 3 : 0);
        c0 = cyc;
        got = 0;
        addr_err = 0;
        for (int t = 1; t <= 100 && !got; t++) begin
            @(negedge clk_in);
            if (v.pause_at > 0 && t == v.pause_at) rdy_in = 1'b0;
            if (v.pause_at > 0 && t == v.pause_at + 3) rdy_in = 1'b1;
            if (v.pause_at == 0 && v.kind != K_ST && t <= n)
                if (mem_a !== v.addr + 32'(t - 1) || mem_wr !== 1'b0) addr_err++;
            if ((v.kind == K_IC && IC_data_en) || (v.kind != K_IC && LSB_data_en)) begin
                got = 1;
                IC_query_en  = 1'b0;
                LSB_query_en = 1'b0;
                check("latency", cyc - c0, lat_exp);
            end
        end
        if (!got) flag("req_timeout");
        if (v.pause_at == 0 && v.kind != K_ST) check("rd_addr_seq", addr_err, 0);
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        vec_t vecs[16];
        int seen, lsb_n, ic_n;
        bit relsb;
        cmp_t e;

        vecs[0]  = '{K_IC, 2'd0, 32'h0000_0100, 32'h0, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 0};
        vecs[1]  = '{K_LD, 2'd2, 32'h0000_0204, 32'h0, 128'h4433_2211, 0};
        vecs[2]  = '{K_LD, 2'd0, 32'h0000_0204, 32'h0, 128'h11, 0};
        vecs[3]  = '{K_LD, 2'd1, 32'h0000_0205, 32'h0, 128'h3322, 0};
        vecs[4]  = '{K_LD, 2'd3, 32'h0000_0204, 32'h0, 128'h4433_2211, 0};
        vecs[5]  = '{K_ST, 2'd1, 32'h0000_0300, 32'h1234_ABCD, 128'h0, 0};
        vecs[6]  = '{K_LD, 2'd2, 32'h0000_0300, 32'h0, 128'h0000_ABCD, 0};
        vecs[7]  = '{K_ST, 2'd2, 32'h0000_0310, 32'hDEAD_BEEF, 128'h0, 0};
        vecs[8]  = '{K_LD, 2'd2, 32'h0000_0310, 32'h0, 128'hDEAD_BEEF, 0};
        vecs[9]  = '{K_LD, 2'd2, 32'hFFFF_FFFE, 32'h0, 128'hA4A3_A2A1, 0};
        vecs[10] = '{K_ST, 2'd0, 32'h0000_0312, 32'h0000_0077, 128'h0, 0};
        vecs[11] = '{K_LD, 2'd2, 32'h0000_0310, 32'h0, 128'hDE77_BEEF, 0};
        vecs[12] = '{K_LD, 2'd2, 32'h0000_0204, 32'h0, 128'h4433_2211, 1};
        vecs[13] = '{K_LD, 2'd2, 32'h0000_0204, 32'h0, 128'h4433_2211, 3};
        vecs[14] = '{K_LD, 2'd2, 32'h0000_0204, 32'h0, 128'h4433_2211, 5};
        vecs[15] = '{K_IC, 2'd0, 32'h0000_0110, 32'h0, 128'h45444746_41404342_4D4C4F4E_49484B4A, 9};

        repeat (3) @(negedge clk_in);
        #1;
        check_zero_outputs("reset");
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);

        for (int i = 0; i < 16; i++) run_req(vecs[i]);

        // Store byte to IO space while the UART buffer is full for 5 cycles.
        @(negedge clk_in);
        io_buffer_full = 1'b1;
        LSB_query_wr = 1'b1; LSB_query_size = 2'b00;
        LSB_query_addr = 32'h0003_0000; LSB_query_data = 32'h0000_005A;
        LSB_query_en = 1'b1;
        wr_q.push_back('{32'h0003_0000, 8'h5A});
        e.is_ic = 1'b0; e.data = '0;
        exp_q.push_back(e);
        seen = 0;
        repeat (5) begin
            @(negedge clk_in);
            #4;
            if (mem_wr || LSB_data_en) seen++;
        end
        check("io_stall_quiet", seen, 0);
        @(negedge clk_in);
        io_buffer_full = 1'b0;
        seen = 0;
        for (int t = 0; t < 20 && seen == 0; t++) begin
            @(negedge clk_in);
            if (LSB_data_en) begin seen = 1; LSB_query_en = 1'b0; end
        end
        if (seen == 0) flag("io_store_timeout");
        repeat (2) @(negedge clk_in);

        // Reset in the middle of a block refill: everything clears and no pulse follows.
        @(negedge clk_in);
        IC_query_addr = 32'h0000_0100;
        IC_query_en = 1'b1;
        repeat (6) @(negedge clk_in);
        rst_in = 1'b1;
        IC_query_en = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (IC_data_en || LSB_data_en) seen++;
        end
        check("no_pulse_after_reset", seen, 0);

        // Simultaneous requests from reset, then both re-request: LSB, IC, LSB.
        @(negedge clk_in);
        IC_query_addr = 32'h0000_0100;
        LSB_query_wr = 1'b0; LSB_query_size = 2'b10; LSB_query_addr = 32'h0000_0204;
        IC_query_en = 1'b1;
        LSB_query_en = 1'b1;
        e.is_ic = 1'b0; e.data = 128'h4433_2211; exp_q.push_back(e);
        e.is_ic = 1'b1; e.data = 128'h0F0E0D0C_0B0A0908_07060504_03020100; exp_q.push_back(e);
        e.is_ic = 1'b0; e.data = 128'h4433_2211; exp_q.push_back(e);
        lsb_n = 0; ic_n = 0; relsb = 0;
        for (int t = 0; t < 200 && !(lsb_n == 2 && ic_n == 1); t++) begin
            @(negedge clk_in);
            if (relsb) begin LSB_query_en = 1'b1; relsb = 0; end
            if (LSB_data_en) begin
                lsb_n++;
                LSB_query_en = 1'b0;
                if (lsb_n == 1) relsb = 1;
            end
            if (IC_data_en) begin ic_n++; IC_query_en = 1'b0; end
        end
        if (!(lsb_n == 2 && ic_n == 1)) flag("round_robin_timeout");

        repeat (5) @(negedge clk_in);
        check("exp_q_empty", exp_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
